// File: rtl/s2mm_writer.sv
// s2mm_writer: stream-to-memory writer.
// Accepts a (base address, word count) command, consumes a valid/ready word
// stream and issues one registered write per word at incrementing addresses.
// Completion is signalled by a one-cycle done pulse; sticky flags record
// whether the stream packet ended early (err_short) or ran past the count
// (err_long).
//
// Handshakes: every channel (cmd, s, m) transfers on the cycle where
// valid && ready are both high at the rising clock edge. A producer holds
// valid and its payload stable until the transfer happens; ready may depend
// combinationally on the other side's ready (s_ready follows m_ready).
module s2mm_writer #(
    parameter int WORD_WIDTH = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [WORD_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [WORD_WIDTH-1:0] m_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err_short,
    output logic                  err_long,
    output logic [LEN_WIDTH-1:0]  words_written,
    output logic [1:0]            state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = LEN_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   next_addr_q, next_addr_d;
    logic [LEN_WIDTH-1:0]    remaining_q, remaining_d;
    logic                    m_valid_q, m_valid_d;
    logic [ADDR_WIDTH-1:0]   m_addr_q, m_addr_d;
    logic [WORD_WIDTH-1:0]   m_data_q, m_data_d;
    logic                    err_short_q, err_short_d;
    logic                    err_long_q, err_long_d;
    logic [LEN_WIDTH-1:0]    words_written_q, words_written_d;
    logic                    m_accept;
    logic                    s_beat;

    // Next-state, handshake and datapath update logic for the command FSM.
    always_comb begin
        state_d         = state_q;
        next_addr_d     = next_addr_q;
        remaining_d     = remaining_q;
        m_valid_d       = m_valid_q;
        m_addr_d        = m_addr_q;
        m_data_d        = m_data_q;
        err_short_d     = err_short_q;
        err_long_d      = err_long_q;
        words_written_d = words_written_q;
        cmd_ready       = 1'b0;
        s_ready         = 1'b0;
        busy            = 1'b0;
        done            = 1'b0;
        s_beat          = 1'b0;
        m_accept        = m_valid_q && m_ready;

        // Memory acceptances are counted whatever the state; m_valid is only
        // ever high in RUN, so this never races the clear on a new command.
        if (m_accept) begin
            words_written_d = words_written_q + LEN_ONE;
        end

        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    next_addr_d     = cmd_addr;
                    remaining_d     = cmd_len;
                    err_short_d     = 1'b0;
                    err_long_d      = 1'b0;
                    words_written_d = '0;
                    state_d         = (cmd_len == '0) ? ST_DONE : ST_RUN;
                end
            end

            ST_RUN: begin
                busy = 1'b1;
                // A new word can only be taken when the output register is
                // empty or being emptied this cycle.
                s_ready = (remaining_q != '0) && (!m_valid_q || m_ready);
                s_beat  = s_valid && s_ready;

                if (m_accept) begin
                    m_valid_d = 1'b0;
                end

                if (s_beat) begin
                    m_valid_d   = 1'b1;
                    m_addr_d    = next_addr_q;
                    m_data_d    = s_data;
                    next_addr_d = next_addr_q + ADDR_ONE;
                    if (s_last && (remaining_q > LEN_ONE)) begin
                        err_short_d = 1'b1;
                        remaining_d = '0;
                    end else begin
                        remaining_d = remaining_q - LEN_ONE;
                    end
                    if ((remaining_q == LEN_ONE) && !s_last) begin
                        err_long_d = 1'b1;
                    end
                end

                // With nothing left to consume, finish once the output
                // register has drained (s_ready is 0 here, so no new beat).
                if ((remaining_q == '0) && (!m_valid_q || m_accept)) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            next_addr_q     <= '0;
            remaining_q     <= '0;
            m_valid_q       <= 1'b0;
            m_addr_q        <= '0;
            m_data_q        <= '0;
            err_short_q     <= 1'b0;
            err_long_q      <= 1'b0;
            words_written_q <= '0;
        end else begin
            state_q         <= state_d;
            next_addr_q     <= next_addr_d;
            remaining_q     <= remaining_d;
            m_valid_q       <= m_valid_d;
            m_addr_q        <= m_addr_d;
            m_data_q        <= m_data_d;
            err_short_q     <= err_short_d;
            err_long_q      <= err_long_d;
            words_written_q <= words_written_d;
        end
    end

    assign m_valid       = m_valid_q;
    assign m_addr        = m_addr_q;
    assign m_data        = m_data_q;
    assign err_short     = err_short_q;
    assign err_long      = err_long_q;
    assign words_written = words_written_q;
    assign state_dbg     = state_q;

endmodule

// File: doc/s2mm_writer.md
Name: s2mm_writer

Overview:
- Stream-to-memory writer; the write-side counterpart of the memory-to-stream read path.
- Accepts a command (base address, word count), then consumes a valid/ready word stream, typically from a skid_buffer output.
- Issues one registered write request per word to a simple valid/ready memory write port at incrementing addresses.
- Reports completion with a one-cycle done pulse and sticky length-mismatch flags.

Parameters:
WORD_WIDTH, 8, data word width in bits
ADDR_WIDTH, 16, memory word address width
LEN_WIDTH, 16, command word-count width

Ports:
clk  in  1  clock, all logic on rising edge
reset_n  in  1  asynchronous, active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_addr  in  ADDR_WIDTH  base word address
cmd_len  in  LEN_WIDTH  number of words to write
s_valid  in  1  stream word offered
s_ready  out  1  stream word accepted when s_valid && s_ready
s_data  in  WORD_WIDTH  stream word
s_last  in  1  final word of stream packet
m_valid  out  1  write request valid (registered)
m_ready  in  1  memory accepts write
m_addr  out  ADDR_WIDTH  write address (registered)
m_data  out  WORD_WIDTH  write data (registered)
busy  out  1  command in progress
done  out  1  one-cycle pulse at command completion
err_short  out  1  sticky: s_last seen before cmd_len words
err_long  out  1  sticky: cmd_len-th word arrived without s_last
words_written  out  LEN_WIDTH  writes accepted by memory for the current or last command

Behaviour:
- Reset (async assert, sync release): state=IDLE; cmd_ready=1, s_ready=0, m_valid=0, m_addr=0, m_data=0, busy=0, done=0, err_*=0, words_written=0. Asserting reset mid-command drops any in-flight write and returns to IDLE. No done pulse is generated.
- States:
  - IDLE: cmd_ready=1, busy=0. On a cmd beat: latch addr into next_addr, latch len into remaining, clear err_* and words_written. Go to RUN, or to DONE if cmd_len==0.
  - RUN: busy=1, cmd_ready=0. s_ready = (remaining!=0) && (!m_valid || m_ready). s_ready is combinational from m_ready; no deeper buffering.
  - DONE: busy=1. done=1 for exactly one cycle, then IDLE. cmd_ready=0 in DONE.
- Stream beat in RUN:
  - Load m_data<=s_data, m_addr<=next_addr, m_valid<=1.
  - next_addr increments by 1, wrapping modulo 2^ADDR_WIDTH.
  - remaining decrements.
- Write path:
  - m_valid/m_addr/m_data hold stable while m_valid && !m_ready.
  - On m_valid && m_ready with no new beat in the same cycle, m_valid<=0.
  - Accept and reload in the same cycle gives full throughput: one word per cycle when m_ready=1.
  - words_written increments on each m_valid && m_ready.
- Termination:
  - Beat with s_last=1 while remaining>1: set err_short, set remaining<=0. That word is still written.
  - Beat with remaining==1 and s_last=0: set err_long. Later stream words are not consumed (s_ready=0).
  - RUN->DONE when remaining==0 and the final write is accepted (m_valid && m_ready with no pending beat), or when remaining==0 and m_valid==0.
- Latency: stream beat to m_valid is 1 cycle. Final write acceptance to done is 1 cycle.
- No write is issued for cmd_len==0. s_ready stays 0 throughout.
- err_* and words_written hold their values until the next command is accepted.

Test Plan:
- Reset: hold reset_n=0 with stimulus toggling -> cmd_ready=1, s_ready=0, m_valid=0, done=0. Release; first command accepted normally.
- Basic: cmd addr=0x0010 len=4, stream 0xA1..0xA4 with s_last on 0xA4, m_ready=1 -> writes (0x10,A1)(0x11,A2)(0x12,A3)(0x13,A4) on consecutive cycles. done pulses once. words_written=4, no errors.
- Backpressure: same command, m_ready low 3 cycles on the 2nd write -> m_addr=0x11/m_data=A2 held stable. s_ready=0 during the stall. No word lost or duplicated.
- Wrap and zero-length:
  - cmd addr=0xFFFE len=3 -> addresses 0xFFFE, 0xFFFF, 0x0000.
  - cmd len=0 -> done 1 cycle after the cmd beat, no m_valid, s_ready never high.
- Length mismatch:
  - len=4 with s_last on the 2nd word -> 2 writes, err_short=1, done pulses.
  - len=2 with no s_last -> 2 writes, err_long=1. The 3rd stream word stays unconsumed.
- Mid-command reset: assert reset_n=0 after the 2nd of 4 beats while m_ready=0 -> m_valid drops immediately, no done pulse. A new command afterwards starts from its own base address.
